// File: rtl/pwm_multi_gen_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode and
// direction encodings, register address map and the reset TOP value.
package pwm_multi_gen_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Address of the TOP register; duties occupy 0..ch-1 below it.
    function automatic int addr_top(input int ch);
        return ch;
    endfunction

    // Address of the {mode, presc} configuration register.
    function automatic int addr_cfg(input int ch);
        return ch + 1;
    endfunction

    // TOP after reset is all ones for a w-bit counter (valid for w <= 32).
    function automatic logic [31:0] top_reset(input int w);
        return (32'h0000_0001 << w) - 32'h0000_0001;
    endfunction

endpackage

// File: rtl/pwm_multi_gen_timebase.sv
// Shared time base: prescaler, edge/center counter and period-boundary
// detection. The boundary is reported on the last tick of a period so the
// counter, direction and the caller's active registers all restart together.
module pwm_timebase
    import pwm_multi_gen_pkg::*;
#(
    parameter int W  = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [W-1:0]  top,
    input  logic [PW-1:0] presc,
    input  logic          mode,
    output logic [W-1:0]  cnt,
    output logic          tick,
    output logic          boundary,
    output logic          sync
);

    localparam logic [W-1:0]  CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0]  CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PCNT_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] pcnt_r;
    logic [PW-1:0] pcnt_nxt_s;
    logic [W-1:0]  cnt_r;
    logic [W-1:0]  cnt_nxt_s;
    pwm_dir_e      dir_r;
    pwm_dir_e      dir_nxt_s;
    logic          tick_s;
    logic          center_s;
    logic          boundary_s;
    logic          sync_r;

    // Next-state logic for prescaler, counter and direction. In center mode
    // the triangle is 0..top..1 (2*top ticks); the tick that would bring the
    // down-count to 0 ends the period and restarts at 0 counting up.
    always_comb begin
        tick_s     = en && (pcnt_r == presc);
        center_s   = (mode == MODE_CENTER) && (top != CNT_ZERO);
        boundary_s = 1'b0;
        pcnt_nxt_s = pcnt_r;
        cnt_nxt_s  = cnt_r;
        dir_nxt_s  = dir_r;
        if (!en) begin
            pcnt_nxt_s = PCNT_ZERO;
            cnt_nxt_s  = CNT_ZERO;
            dir_nxt_s  = DIR_UP;
        end else if (tick_s) begin
            pcnt_nxt_s = PCNT_ZERO;
            if (center_s) begin
                if (dir_r == DIR_DOWN) begin
                    if (cnt_r == CNT_ONE) begin
                        boundary_s = 1'b1;
                        cnt_nxt_s  = CNT_ZERO;
                        dir_nxt_s  = DIR_UP;
                    end else begin
                        cnt_nxt_s  = cnt_r - CNT_ONE;
                        dir_nxt_s  = DIR_DOWN;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    if (cnt_r == (top - CNT_ONE)) begin
                        dir_nxt_s = DIR_DOWN;
                    end else begin
                        dir_nxt_s = DIR_UP;
                    end
                end
            end else begin
                if (cnt_r == top) begin
                    boundary_s = 1'b1;
                    cnt_nxt_s  = CNT_ZERO;
                end else begin
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                end
                dir_nxt_s = DIR_UP;
            end
        end else begin
            pcnt_nxt_s = pcnt_r + PCNT_ONE;
        end
    end

    // Time-base state registers and the registered period-start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_r <= PCNT_ZERO;
            cnt_r  <= CNT_ZERO;
            dir_r  <= DIR_UP;
            sync_r <= 1'b0;
        end else begin
            pcnt_r <= pcnt_nxt_s;
            cnt_r  <= cnt_nxt_s;
            dir_r  <= dir_nxt_s;
            sync_r <= boundary_s;
        end
    end

    assign cnt      = cnt_r;
    assign tick     = tick_s;
    assign boundary = boundary_s;
    assign sync     = sync_r;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: write decode into staging registers, active
// registers reloaded only at period boundaries (or while stopped), and one
// comparator per channel against the shared time-base counter.
module pwm_multi_gen
    import pwm_multi_gen_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 8,
    parameter int PW = 4,
    parameter int AW = $clog2(CH + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic [CH-1:0] pwm,
    output logic          sync
);

    localparam logic [W-1:0]  TOP_RST  = W'(top_reset(W));
    localparam logic [W-1:0]  DUTY_RST = {W{1'b0}};
    localparam logic [PW-1:0] PRESC_RST = {PW{1'b0}};

    logic [CH-1:0][W-1:0] stg_duty_r;
    logic [W-1:0]         stg_top_r;
    logic                 stg_mode_r;
    logic [PW-1:0]        stg_presc_r;

    logic [CH-1:0][W-1:0] act_duty_r;
    logic [W-1:0]         act_top_r;
    logic                 act_mode_r;
    logic [PW-1:0]        act_presc_r;

    logic [CH-1:0]        wr_duty_s;
    logic                 wr_top_s;
    logic                 wr_cfg_s;
    logic                 load_s;
    logic [W-1:0]         cnt_s;
    logic                 tick_s;
    logic                 boundary_s;
    logic [CH-1:0]        pwm_nxt_s;
    logic [CH-1:0]        pwm_r;

    pwm_timebase #(
        .W  (W),
        .PW (PW)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .top      (act_top_r),
        .presc    (act_presc_r),
        .mode     (act_mode_r),
        .cnt      (cnt_s),
        .tick     (tick_s),
        .boundary (boundary_s),
        .sync     (sync)
    );

    // Write address decode; addresses past the config register select nothing.
    always_comb begin
        wr_duty_s = {CH{1'b0}};
        wr_top_s  = 1'b0;
        wr_cfg_s  = 1'b0;
        if (wr_en) begin
            for (int i = 0; i < CH; i++) begin
                if (wr_addr == AW'(i)) begin
                    wr_duty_s[i] = 1'b1;
                end else begin
                    wr_duty_s[i] = 1'b0;
                end
            end
            wr_top_s = (wr_addr == AW'(addr_top(CH)));
            wr_cfg_s = (wr_addr == AW'(addr_cfg(CH)));
        end else begin
            wr_duty_s = {CH{1'b0}};
        end
    end

    // Active bank follows staging while stopped and at each period end, so a
    // write landing in the boundary cycle waits for the following boundary.
    assign load_s = !en || (tick_s && boundary_s);

    // Staging register bank, written directly from the write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_duty_r  <= {CH{DUTY_RST}};
            stg_top_r   <= TOP_RST;
            stg_mode_r  <= MODE_EDGE;
            stg_presc_r <= PRESC_RST;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr_duty_s[i]) begin
                    stg_duty_r[i] <= wr_data;
                end
            end
            if (wr_top_s) begin
                stg_top_r <= wr_data;
            end
            if (wr_cfg_s) begin
                stg_mode_r  <= wr_data[W-1];
                stg_presc_r <= wr_data[PW-1:0];
            end
        end
    end

    // Active register bank, loaded as a whole from staging.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_duty_r  <= {CH{DUTY_RST}};
            act_top_r   <= TOP_RST;
            act_mode_r  <= MODE_EDGE;
            act_presc_r <= PRESC_RST;
        end else if (load_s) begin
            act_duty_r  <= stg_duty_r;
            act_top_r   <= stg_top_r;
            act_mode_r  <= stg_mode_r;
            act_presc_r <= stg_presc_r;
        end
    end

    // Per-channel comparators; forced low while stopped.
    for (genvar g = 0; g < CH; g++) begin : g_cmp
        assign pwm_nxt_s[g] = en && (cnt_s < act_duty_r[g]);
    end

    // Output register so every channel switches on the same clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_r <= {CH{1'b0}};
        end else begin
            pwm_r <= pwm_nxt_s;
        end
    end

    assign pwm = pwm_r;

endmodule
